// File: rtl/vic_bus_addr_gen_pkg.sv
// Shared constants for the VIC bus address generator:
// cycle_type encodings, idle address and ECM address mask.
package vic_bus_addr_gen_pkg;

    localparam logic [3:0] VIC_LP   = 4'd0;
    localparam logic [3:0] VIC_HS1  = 4'd1;
    localparam logic [3:0] VIC_LS2  = 4'd2;
    localparam logic [3:0] VIC_HS3  = 4'd3;
    localparam logic [3:0] VIC_LR   = 4'd4;
    localparam logic [3:0] VIC_HRC  = 4'd5;
    localparam logic [3:0] VIC_HGC  = 4'd6;
    localparam logic [3:0] VIC_LG   = 4'd7;
    localparam logic [3:0] VIC_HPI1 = 4'd8;
    localparam logic [3:0] VIC_LPI2 = 4'd9;
    localparam logic [3:0] VIC_HPI3 = 4'd10;
    localparam logic [3:0] VIC_HRI  = 4'd11;
    localparam logic [3:0] VIC_HRX  = 4'd12;
    localparam logic [3:0] VIC_HGI  = 4'd13;
    localparam logic [3:0] VIC_LI   = 4'd14;
    localparam logic [3:0] VIC_HI   = 4'd15;

    localparam logic [13:0] IDLE_ADDR_DEF = 14'h3FFF;
    localparam logic [13:0] ECM_MASK      = 14'h39FF;

endpackage

// File: rtl/vic_bus_addr_gen_if.sv
// Fetch bus between the cycle sequencer and the address generator.
// master drives strobes/type/data; slave returns vic_addr.
interface vic_bus_addr_gen_if;

    logic        phi_phase_start_1;
    logic        phi_phase_start_dav;
    logic [3:0]  cycle_type;
    logic [2:0]  sprite_cnt;
    logic [11:0] dbi;
    logic [13:0] vic_addr;

    modport master (
        output phi_phase_start_1,
        output phi_phase_start_dav,
        output cycle_type,
        output sprite_cnt,
        output dbi,
        input  vic_addr
    );

    modport slave (
        input  phi_phase_start_1,
        input  phi_phase_start_dav,
        input  cycle_type,
        input  sprite_cnt,
        input  dbi,
        output vic_addr
    );

endinterface

// File: rtl/vic_refresh_counter.sv
// DRAM refresh counter: frame_start load beats decrement.
// Ports: clk_dot4x, rst, frame_start, dec in; refc out.
module vic_refresh_counter #(
    parameter logic [7:0] REFC_RESET = 8'hFF
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       dec,
    output logic [7:0] refc
);

    always_ff @(posedge clk_dot4x) begin
        if (rst)
            refc <= REFC_RESET;
        else if (frame_start)
            refc <= REFC_RESET;
        else if (dec)
            refc <= refc - 8'd1;
    end

endmodule

// File: rtl/vic_bus_addr_gen.sv
// Turns the fetch classification into the VIC address; latches
// c-access data and sprite pointers. Ports: clk_dot4x, rst, bus
// (strobes/type/sprite_cnt/dbi in, vic_addr out), mode/counter
// inputs, refc/char_out/sprite_ptr out.
module vic_bus_addr_gen
    import vic_bus_addr_gen_pkg::*;
#(
    parameter logic [13:0] IDLE_ADDR  = IDLE_ADDR_DEF,
    parameter logic [7:0]  REFC_RESET = 8'hFF
) (
    input  logic                 clk_dot4x,
    input  logic                 rst,
    vic_bus_addr_gen_if.slave    bus,
    input  logic [5:0]           sprite_mc,
    input  logic [9:0]           vc,
    input  logic [2:0]           rc,
    input  logic                 idle,
    input  logic                 ecm,
    input  logic                 bmm,
    input  logic [3:0]           vm,
    input  logic [2:0]           cb,
    input  logic                 frame_start,
    input  logic [7:0]           char_buf_in,
    output logic [7:0]           refc,
    output logic [11:0]          char_out,
    output logic [7:0]           sprite_ptr
);

    logic [7:0]  ptr_q [8];
    logic        prev_c;
    logic [7:0]  code;
    logic [13:0] addr_d;
    logic        is_c;
    logic        dec;

    assign is_c = (bus.cycle_type == VIC_HRC) ||
                  (bus.cycle_type == VIC_HGC);
    assign dec = bus.phi_phase_start_dav &&
                 (bus.cycle_type == VIC_LR);
    assign sprite_ptr = ptr_q[bus.sprite_cnt];

    vic_refresh_counter #(
        .REFC_RESET (REFC_RESET)
    ) u_refc (
        .clk_dot4x   (clk_dot4x),
        .rst         (rst),
        .frame_start (frame_start),
        .dec         (dec),
        .refc        (refc)
    );

    // Badline g-access uses the code fetched in the preceding
    // c-access; otherwise the line buffer supplies it.
    always_comb begin
        code   = prev_c ? char_out[7:0] : char_buf_in;
        addr_d = IDLE_ADDR;
        case (bus.cycle_type)
            VIC_LP:
                addr_d = {vm, 7'h7F, bus.sprite_cnt};
            VIC_HS1, VIC_LS2, VIC_HS3:
                addr_d = {ptr_q[bus.sprite_cnt], sprite_mc};
            VIC_LR:
                addr_d = {6'h3F, refc};
            VIC_HRC, VIC_HGC:
                addr_d = {vm, vc};
            VIC_LG: begin
                if (idle)
                    addr_d = IDLE_ADDR;
                else if (bmm)
                    addr_d = {cb[2], vc, rc};
                else
                    addr_d = {cb, code, rc};
                if (ecm)
                    addr_d = addr_d & ECM_MASK;
            end
            default:
                addr_d = IDLE_ADDR;
        endcase
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            bus.vic_addr <= IDLE_ADDR;
            char_out     <= '0;
            prev_c       <= 1'b0;
            for (int i = 0; i < 8; i++)
                ptr_q[i] <= '0;
        end else begin
            if (bus.phi_phase_start_1) begin
                bus.vic_addr <= addr_d;
                if (is_c)
                    prev_c <= 1'b1;
                else if (bus.cycle_type == VIC_LG)
                    prev_c <= 1'b0;
            end
            if (bus.phi_phase_start_dav) begin
                if (is_c)
                    char_out <= bus.dbi;
                else if (bus.cycle_type == VIC_LP)
                    ptr_q[bus.sprite_cnt] <= bus.dbi[7:0];
            end
        end
    end

    assert property (@(posedge clk_dot4x) disable iff (rst)
        !(bus.phi_phase_start_1 && bus.phi_phase_start_dav));

endmodule

// File: tb/tb_vic_bus_addr_gen.sv
// Directed bench for vic_bus_addr_gen.
// One task per scenario, hand-computed expectations.
module tb_vic_bus_addr_gen;
    import vic_bus_addr_gen_pkg::*;

    logic        clk_dot4x = 1'b0;
    logic        rst;
    logic [5:0]  sprite_mc;
    logic [9:0]  vc;
    logic [2:0]  rc;
    logic        idle, ecm, bmm;
    logic [3:0]  vm;
    logic [2:0]  cb;
    logic        frame_start;
    logic [7:0]  char_buf_in;
    logic [7:0]  refc;
    logic [11:0] char_out;
    logic [7:0]  sprite_ptr;

    int errors = 0;
    int checks = 0;

    vic_bus_addr_gen_if bus();

    vic_bus_addr_gen dut (
        .clk_dot4x   (clk_dot4x),
        .rst         (rst),
        .bus         (bus),
        .sprite_mc   (sprite_mc),
        .vc          (vc),
        .rc          (rc),
        .idle        (idle),
        .ecm         (ecm),
        .bmm         (bmm),
        .vm          (vm),
        .cb          (cb),
        .frame_start (frame_start),
        .char_buf_in (char_buf_in),
        .refc        (refc),
        .char_out    (char_out),
        .sprite_ptr  (sprite_ptr)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    task automatic tick();
        @(posedge clk_dot4x);
        #1;
    endtask

    // One fetch: address strobe, gap tick, data strobe.
    // addr holds vic_addr right after the address strobe.
    task automatic fetch(input logic [3:0] ct,
                         input logic [11:0] d,
                         output logic [13:0] addr);
        bus.cycle_type = ct;
        bus.dbi = d;
        bus.phi_phase_start_1 = 1'b1;
        tick();
        addr = bus.vic_addr;
        bus.phi_phase_start_1 = 1'b0;
        tick();
        bus.phi_phase_start_dav = 1'b1;
        tick();
        bus.phi_phase_start_dav = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.vic_addr !== 14'h3FFF) begin
            errors++;
            $display("FAIL reset_addr got=%h exp=3fff", bus.vic_addr);
        end
        checks++;
        if (refc !== 8'hFF) begin
            errors++;
            $display("FAIL reset_refc got=%h exp=ff", refc);
        end
        checks++;
        if (char_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_char got=%h exp=000", char_out);
        end
        checks++;
        if (sprite_ptr !== 8'h00) begin
            errors++;
            $display("FAIL reset_ptr got=%h exp=00", sprite_ptr);
        end
    endtask

    task automatic test_refresh();
        logic [13:0] a;
        logic [7:0]  r;
        bus.cycle_type = VIC_LR;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r = 8'hFF - 8'(i);
            checks++;
            if (refc !== r) begin
                errors++;
                $display("FAIL refc_seq%0d got=%h exp=%h", i, refc, r);
            end
            fetch(VIC_LR, 12'h000, a);
            checks++;
            if (a !== {6'h3F, r}) begin
                errors++;
                $display("FAIL lr_addr%0d got=%h exp=%h",
                         i, a, {6'h3F, r});
            end
        end
        // refc now FA; walk down to 00
        for (int i = 0; i < 250; i++)
            fetch(VIC_LR, 12'h000, a);
        checks++;
        if (refc !== 8'h00) begin
            errors++;
            $display("FAIL refc_zero got=%h exp=00", refc);
        end
        fetch(VIC_LR, 12'h000, a);
        checks++;
        if (refc !== 8'hFF) begin
            errors++;
            $display("FAIL refc_wrap got=%h exp=ff", refc);
        end
        fetch(VIC_LR, 12'h000, a);
        // refc FE; load coincident with decrement
        bus.cycle_type = VIC_LR;
        bus.phi_phase_start_dav = 1'b1;
        frame_start = 1'b1;
        tick();
        bus.phi_phase_start_dav = 1'b0;
        frame_start = 1'b0;
        checks++;
        if (refc !== 8'hFF) begin
            errors++;
            $display("FAIL refc_load_wins got=%h exp=ff", refc);
        end
    endtask

    task automatic test_sprite();
        logic [13:0] a;
        vm = 4'h1;
        bus.sprite_cnt = 3'd3;
        fetch(VIC_LP, 12'h080, a);
        checks++;
        if (a !== 14'h07FB) begin
            errors++;
            $display("FAIL lp_addr got=%h exp=07fb", a);
        end
        checks++;
        if (sprite_ptr !== 8'h80) begin
            errors++;
            $display("FAIL sprite_ptr got=%h exp=80", sprite_ptr);
        end
        sprite_mc = 6'h05;
        fetch(VIC_HS1, 12'h000, a);
        checks++;
        if (a !== 14'h2005) begin
            errors++;
            $display("FAIL hs1_addr got=%h exp=2005", a);
        end
        bus.sprite_cnt = 3'd2;
        tick();
        checks++;
        if (sprite_ptr !== 8'h00) begin
            errors++;
            $display("FAIL other_ptr got=%h exp=00", sprite_ptr);
        end
    endtask

    task automatic test_badline();
        logic [13:0] a;
        vm = 4'h1;
        vc = 10'h02A;
        cb = 3'b010;
        rc = 3'd5;
        bmm = 1'b0;
        ecm = 1'b0;
        idle = 1'b0;
        char_buf_in = 8'h20;
        fetch(VIC_HGC, 12'hA41, a);
        checks++;
        if (a !== 14'h042A) begin
            errors++;
            $display("FAIL hgc_addr got=%h exp=042a", a);
        end
        checks++;
        if (char_out !== 12'hA41) begin
            errors++;
            $display("FAIL char_out got=%h exp=a41", char_out);
        end
        fetch(VIC_LG, 12'h000, a);
        checks++;
        if (a !== 14'h120D) begin
            errors++;
            $display("FAIL lg_badline got=%h exp=120d", a);
        end
        fetch(VIC_HGC, 12'hA41, a);
        ecm = 1'b1;
        fetch(VIC_LG, 12'h000, a);
        checks++;
        if (a !== 14'h100D) begin
            errors++;
            $display("FAIL lg_ecm got=%h exp=100d", a);
        end
        fetch(VIC_HGC, 12'hA41, a);
        ecm = 1'b0;
        bmm = 1'b1;
        fetch(VIC_LG, 12'h000, a);
        checks++;
        if (a !== 14'h0155) begin
            errors++;
            $display("FAIL lg_bmm got=%h exp=0155", a);
        end
        bmm = 1'b0;
    endtask

    task automatic test_nonbadline();
        logic [13:0] a;
        fetch(VIC_HGI, 12'h000, a);
        checks++;
        if (a !== 14'h3FFF) begin
            errors++;
            $display("FAIL hgi_addr got=%h exp=3fff", a);
        end
        fetch(VIC_LG, 12'h000, a);
        checks++;
        if (a !== 14'h1105) begin
            errors++;
            $display("FAIL lg_linebuf got=%h exp=1105", a);
        end
        idle = 1'b1;
        fetch(VIC_LG, 12'h000, a);
        checks++;
        if (a !== 14'h3FFF) begin
            errors++;
            $display("FAIL lg_idle got=%h exp=3fff", a);
        end
        ecm = 1'b1;
        fetch(VIC_LG, 12'h000, a);
        checks++;
        if (a !== 14'h39FF) begin
            errors++;
            $display("FAIL lg_idle_ecm got=%h exp=39ff", a);
        end
        idle = 1'b0;
        ecm = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [13:0] a;
        fetch(VIC_LR, 12'h000, a);
        // refc FE now
        bus.cycle_type = VIC_LR;
        bus.phi_phase_start_1 = 1'b1;
        tick();
        bus.phi_phase_start_1 = 1'b0;
        checks++;
        if (bus.vic_addr !== 14'h3FFE) begin
            errors++;
            $display("FAIL lr_pre_rst got=%h exp=3ffe", bus.vic_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.vic_addr !== 14'h3FFF) begin
            errors++;
            $display("FAIL rst_mid_addr got=%h exp=3fff", bus.vic_addr);
        end
        checks++;
        if (refc !== 8'hFF || char_out !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_regs refc=%h char=%h exp=ff/000",
                     refc, char_out);
        end
        bus.sprite_cnt = 3'd3;
        tick();
        checks++;
        if (sprite_ptr !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_ptr got=%h exp=00", sprite_ptr);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.phi_phase_start_1 = 1'b0;
        bus.phi_phase_start_dav = 1'b0;
        bus.cycle_type = VIC_HI;
        bus.sprite_cnt = 3'd0;
        bus.dbi = 12'h000;
        sprite_mc = 6'h00;
        vc = 10'h000;
        rc = 3'd0;
        idle = 1'b0;
        ecm = 1'b0;
        bmm = 1'b0;
        vm = 4'h0;
        cb = 3'd0;
        frame_start = 1'b0;
        char_buf_in = 8'h00;
        test_reset();
        test_refresh();
        test_sprite();
        test_badline();
        test_nonbadline();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
